alu_iterative: RTL and testbench

Sequential execute unit that consumes the 4-bit ALU `Operation` code produced by the ALU controller and returns a 32-bit result plus `Zero` flag. It sits in the EX stage and performs shifts one bit per cycle to save area, so it uses a valid/ready handshake on both operand input and result output. Compare operations return 1 or 0 in `ALUResult[0]` for branch resolution and SLT/SLTU write-back.

---
 rtl/alu_iterative.sv | 155 +++++++++++++++
 tb/tb_alu_iterative.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iterative.sv
// rtl/alu_iterative.sv - iterative EX-stage ALU with bit-serial shifter and valid/ready handshakes
module alu_iterative #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero
);

    localparam int SW = $clog2(DATA_WIDTH);
    localparam logic [SW-1:0] CNT_ZERO = '0;
    localparam logic [SW-1:0] CNT_ONE  = SW'(1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_EQ   = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_NE   = 4'b1011;
    localparam logic [3:0] OP_LT   = 4'b1100;
    localparam logic [3:0] OP_GE   = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   acc_q, acc_d;
    logic [SW-1:0]           cnt_q, cnt_d;
    logic [3:0]              op_q, op_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;

    logic [SW-1:0]           shamt;
    logic                    is_shift;
    logic [DATA_WIDTH-1:0]   alu_res;
    logic [DATA_WIDTH-1:0]   acc_shifted;

    assign shamt    = SrcB[SW-1:0];
    assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);

    // Single-cycle result for every non-shift opcode; compares land in bit 0.
    always_comb begin
        alu_res = '0;
        case (Operation)
            OP_AND:  alu_res = SrcA & SrcB;
            OP_SUB:  alu_res = SrcA - SrcB;
            OP_ADD:  alu_res = SrcA + SrcB;
            OP_OR:   alu_res = SrcA | SrcB;
            OP_XOR:  alu_res = SrcA ^ SrcB;
            OP_EQ:   alu_res[0] = (SrcA == SrcB);
            OP_SLT:  alu_res[0] = ($signed(SrcA) < $signed(SrcB));
            OP_SLTU: alu_res[0] = (SrcA < SrcB);
            OP_NE:   alu_res[0] = (SrcA != SrcB);
            OP_LT:   alu_res[0] = ($signed(SrcA) < $signed(SrcB));
            OP_GE:   alu_res[0] = !($signed(SrcA) < $signed(SrcB));
            default: alu_res = '0;
        endcase
    end

    // One-bit step of the captured shift opcode applied to the accumulator.
    always_comb begin
        acc_shifted = acc_q;
        case (op_q)
            OP_SLL:  acc_shifted = {acc_q[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  acc_shifted = {1'b0, acc_q[DATA_WIDTH-1:1]};
            OP_SRA:  acc_shifted = {acc_q[DATA_WIDTH-1], acc_q[DATA_WIDTH-1:1]};
            default: acc_shifted = acc_q;
        endcase
    end

    // Next-state logic; flush overrides everything and leaves the last result in place.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_d = Operation;
                        if (is_shift && (shamt != CNT_ZERO)) begin
                            acc_d   = SrcA;
                            cnt_d   = shamt;
                            state_d = S_SHIFT;
                        end else if (is_shift) begin
                            result_d = SrcA;
                            state_d  = S_DONE;
                        end else begin
                            result_d = alu_res;
                            state_d  = S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    acc_d = acc_shifted;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        result_d = acc_shifted;
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign ALUResult = result_q;
    assign Zero      = out_valid && (result_q == '0);

endmodule

// File: tb/tb_alu_iterative.sv
// tb/tb_alu_iterative.sv - directed scoreboard bench for alu_iterative
module tb_alu_iterative;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        int          lat;
    } exp_t;

    exp_t sb[$];

    alu_iterative #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .Zero      (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for its result, compare against the scoreboard, then
    // optionally hold out_ready low for 'hold' cycles before the handshake.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        e.res  = exp_res;
        e.zero = (exp_res == 32'h0);
        e.lat  = exp_lat;
        sb.push_back(e);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        SrcA      = $urandom;
        SrcB      = $urandom;
        Operation = 4'($urandom_range(0, 15));
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.scoreboard: observed=empty expected=entry", tag);
        end else begin
            got = sb.pop_front();
            check({tag, ".latency"}, 32'(lat), 32'(got.lat));
            check({tag, ".result"}, ALUResult, got.res);
            check({tag, ".zero"}, 32'(Zero), 32'(got.zero));
            last_res = got.res;
        end
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            Operation = 4'b0010;
            SrcA      = 32'h1111_1111;
            SrcB      = 32'h2222_2222;
            tick();
            check({tag, ".hold_result"}, ALUResult, exp_res);
            check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, ".hold_out_valid"}, 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".post_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
        if (hold > 0) begin
            tick();
            check({tag, ".ignored_op"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        logic seen_valid;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Operation = 4'h0;
        SrcA      = 32'h0;
        SrcB      = 32'h0;
        last_res  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.result", ALUResult, 32'h0);
        check("reset.zero", 32'(Zero), 32'd0);
        rst_n = 1'b1;
        tick();

        do_op("add_wrap", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 0);
        do_op("sub_zero", 4'b0001, 32'h5, 32'h5, 32'h0, 1, 0);
        do_op("and", 4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1, 0);
        do_op("or", 4'b0011, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1, 0);
        do_op("sra31", 4'b0111, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32, 0);
        do_op("srl31", 4'b0110, 32'h8000_0000, 32'd31, 32'h0000_0001, 32, 0);
        do_op("sll_sh0", 4'b0101, 32'h1, 32'h20, 32'h1, 1, 0);
        do_op("sll4", 4'b0101, 32'h1, 32'd4, 32'h10, 5, 0);
        do_op("sra_pos2", 4'b0111, 32'h4000_0000, 32'd2, 32'h1000_0000, 3, 0);
        do_op("slt", 4'b1001, 32'hFFFF_FFFF, 32'h1, 32'h1, 1, 0);
        do_op("sltu", 4'b1010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0);
        do_op("lt", 4'b1100, 32'hFFFF_FFFF, 32'h1, 32'h1, 1, 0);
        do_op("ge", 4'b1101, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0);
        do_op("eq", 4'b1000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0);
        do_op("ne", 4'b1011, 32'hFFFF_FFFF, 32'h1, 32'h1, 1, 0);
        do_op("undef", 4'b1111, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0);
        do_op("xor_bp", 4'b0100, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1, 10);

        // Flush three cycles into a 20-bit SLL, with a competing in_valid.
        Operation = 4'b0101;
        SrcA      = 32'h1;
        SrcB      = 32'd20;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        repeat (2) tick();
        flush     = 1'b1;
        in_valid  = 1'b1;
        Operation = 4'b0010;
        SrcA      = 32'h2;
        SrcB      = 32'h3;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        check("flush.in_ready", 32'(in_ready), 32'd1);
        check("flush.out_valid", 32'(out_valid), 32'd0);
        check("flush.result_kept", ALUResult, last_res);
        seen_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        check("flush.never_valid", 32'(seen_valid), 32'd0);

        // Flush in IDLE blocks a simultaneous in_valid.
        flush     = 1'b1;
        in_valid  = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        tick();
        check("flush_idle.out_valid", 32'(out_valid), 32'd0);
        check("flush_idle.in_ready", 32'(in_ready), 32'd1);

        do_op("add_after_flush", 4'b0010, 32'h2, 32'h3, 32'h5, 1, 0);

        // Asynchronous reset in the middle of a long shift.
        Operation = 4'b0111;
        SrcA      = 32'h8000_0000;
        SrcB      = 32'd31;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.out_valid", 32'(out_valid), 32'd0);
        check("async_rst.result", ALUResult, 32'h0);
        check("async_rst.in_ready", 32'(in_ready), 32'd1);
        check("async_rst.zero", 32'(Zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_op("add_after_rst", 4'b0010, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
